// File: rtl/sh_reg_ctrl_pkg.sv
// Shared types and constants for the shift-register controller.
// Holds the FSM state encoding, direction constants and the default step size.
package sh_reg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_SETTLE = 3'd4,
      ST_RESP   = 3'd5
   } state_e;

   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_LEFT  = 1'b0;

   localparam int MAX_STEP_DEFAULT = 7;

   // Per-cycle shift: the smaller of what is left and the datapath limit.
   function automatic logic [2:0] step_of(input int unsigned rem, input int unsigned max_step);
      return (rem > max_step) ? 3'(max_step) : 3'(rem);
   endfunction

endpackage

// File: rtl/sh_reg_ctrl_if.sv
// Command / response bundle between a requester and the shift-register controller.
// Both channels: a transfer happens on a rising edge where valid and ready are both 1;
// the source holds valid and its payload stable until that edge.
interface sh_reg_ctrl_if #(
   parameter int AMT_W = 5
) ();

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_clr;
   logic             cmd_dir;
   logic [AMT_W-1:0] cmd_amt;
   logic [7:0]       cmd_data;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [7:0]       rsp_data;

   modport master (
      output cmd_valid, cmd_clr, cmd_dir, cmd_amt, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_clr, cmd_dir, cmd_amt, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/sh_reg_ctrl.sv
// Controller that loads an external 8-bit shift register, shifts it by a requested
// total amount in chunks of at most MAX_STEP per cycle, and returns the result.
module sh_reg_ctrl
   import sh_reg_pkg::*;
#(
   parameter int AMT_W    = 5,
   parameter int MAX_STEP = MAX_STEP_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   sh_reg_ctrl_if.slave bus,
   output logic         sr_rst,
   output logic         sr_load,
   output logic         sr_shift_r_l,
   output logic [2:0]   sr_sh,
   output logic [7:0]   sr_d_in,
   input  logic [7:0]   sr_q,
   output logic         busy,
   output state_e       dbg_state_o
);

   state_e           state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       rsp_data_q, rsp_data_d;
   logic [2:0]       step;

   assign step = step_of(32'(rem_q), MAX_STEP);

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      dir_d      = dir_q;
      data_d     = data_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               dir_d   = bus.cmd_dir;
               rem_d   = bus.cmd_amt;
               data_d  = bus.cmd_data;
               state_d = bus.cmd_clr ? ST_CLEAR : ST_LOAD;
            end
         end
         ST_CLEAR: state_d = ST_SETTLE;
         ST_LOAD:  state_d = (rem_q != '0) ? ST_SHIFT : ST_SETTLE;
         ST_SHIFT: begin
            // step never exceeds rem_q, so the subtraction cannot wrap
            rem_d = rem_q - AMT_W'(step);
            if (rem_q == AMT_W'(step)) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            rsp_data_d = sr_q;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         dir_q      <= 1'b0;
         data_q     <= 8'h00;
         rsp_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         dir_q      <= dir_d;
         data_q     <= data_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // Outputs decode registered state only; rst gates them so they read 0 during reset.
   assign bus.cmd_ready = (state_q == ST_IDLE) & ~rst;
   assign busy          = (state_q != ST_IDLE) & ~rst;
   assign bus.rsp_valid = (state_q == ST_RESP) & ~rst;
   assign bus.rsp_data  = rsp_data_q;
   assign sr_rst        = rst | (state_q == ST_CLEAR);
   assign sr_load       = (state_q == ST_LOAD) & ~rst;
   assign sr_d_in       = sr_load ? data_q : 8'h00;
   assign sr_sh         = ((state_q == ST_SHIFT) && !rst) ? step : 3'd0;
   assign sr_shift_r_l  = (state_q == ST_SHIFT) & dir_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sh_reg_ctrl.sv
// Directed bench for sh_reg_ctrl: a ones-fill shift register stand-in, a command-level
// model (step list, final word, latency) and a per-cycle output monitor.
module tb_sh_reg_ctrl;
   import sh_reg_pkg::*;

   logic       clk;
   logic       rst;
   logic       sr_rst, sr_load, sr_shift_r_l, busy;
   logic [2:0] sr_sh;
   logic [7:0] sr_d_in, sr_q;
   state_e     dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int sr_rst_cnt  = 0;
   int sr_load_cnt = 0;

   logic [2:0] exp_sh_q[$];
   logic [7:0] exp_q[$];
   logic       exp_dir;
   logic [7:0] exp_data;

   sh_reg_ctrl_if #(.AMT_W(5)) bus ();

   sh_reg_ctrl #(.AMT_W(5), .MAX_STEP(7)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .sr_rst(sr_rst),
      .sr_load(sr_load),
      .sr_shift_r_l(sr_shift_r_l),
      .sr_sh(sr_sh),
      .sr_d_in(sr_d_in),
      .sr_q(sr_q),
      .busy(busy),
      .dbg_state_o(dbg_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // shift register stand-in: vacated bit positions fill with ones
   always @(posedge clk) begin
      logic [7:0] ones;
      ones = 8'hFF;
      if (sr_rst)           sr_q <= 8'h00;
      else if (sr_load)     sr_q <= sr_d_in;
      else if (sr_sh != 0) begin
         if (sr_shift_r_l) sr_q <= (sr_q >> sr_sh) | ~(ones >> sr_sh);
         else              sr_q <= (sr_q << sr_sh) | ~(ones << sr_sh);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_shift(input logic [7:0] d, input logic dir, input int amt);
      logic [7:0] r;
      r = d;
      for (int i = 0; i < amt; i++) r = dir ? {1'b1, r[7:1]} : {r[6:0], 1'b1};
      return r;
   endfunction

   task automatic push_steps(input int amt);
      int rem;
      int s;
      rem = amt;
      while (rem > 0) begin
         s = (rem > 7) ? 7 : rem;
         exp_sh_q.push_back(3'(s));
         rem -= s;
      end
   endtask

   // Drives one command and waits for rsp_valid; lat counts edges from the accept edge.
   task automatic send_cmd(input string name, input logic clr, input logic dir,
                           input logic [4:0] amt, input logic [7:0] data,
                           input int lat_exp, input logic [7:0] lit);
      int lat;
      exp_dir  = dir;
      exp_data = data;
      if (clr) exp_q.push_back(8'h00);
      else begin
         push_steps(int'(amt));
         exp_q.push_back(model_shift(data, dir, int'(amt)));
      end
      chk({name, "_cmd_ready"}, bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_clr   = clr;
      bus.cmd_dir   = dir;
      bus.cmd_amt   = amt;
      bus.cmd_data  = data;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, lat, lat_exp);
      chk({name, "_rsp_lit"}, bus.rsp_data, lit);
   endtask

   task automatic finish_resp(input string name);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk({name, "_valid_drop"}, bus.rsp_valid, 0);
      chk({name, "_idle_ready"}, bus.cmd_ready, 1);
   endtask

   // scoreboard / per-cycle monitor
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_cmd_ready", bus.cmd_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_sr_load", sr_load, 0);
            chk("rst_sr_sh", sr_sh, 0);
            chk("rst_sr_d_in", sr_d_in, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_sr_rst", sr_rst, 1);
         end else begin
            if (sr_rst) sr_rst_cnt++;
            if (sr_load) begin
               sr_load_cnt++;
               chk("sr_d_in", sr_d_in, exp_data);
            end
            chk("busy_vs_ready", busy, !bus.cmd_ready);
            if (sr_sh != 0) begin
               if (exp_sh_q.size() == 0) chk("sh_unexpected", sr_sh, 0);
               else begin
                  chk("sr_sh", sr_sh, exp_sh_q.pop_front());
                  chk("sr_dir", sr_shift_r_l, exp_dir);
               end
            end
            if (bus.rsp_valid) begin
               if (exp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
               else begin
                  chk("rsp_data", bus.rsp_data, exp_q[0]);
                  if (bus.rsp_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // directed stimulus
   initial begin
      int c0;
      int n;
      logic saw;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_clr   = 1'b0;
      bus.cmd_dir   = 1'b0;
      bus.cmd_amt   = '0;
      bus.cmd_data  = 8'h00;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset_cmd_ready", bus.cmd_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_rsp_valid", bus.rsp_valid, 0);
      chk("reset_rsp_data", bus.rsp_data, 8'h00);
      @(posedge clk); #1;

      send_cmd("a5_r3", 1'b0, DIR_RIGHT, 5'd3, 8'hA5, 4, 8'hF4);
      finish_resp("a5_r3");
      send_cmd("81_r10", 1'b0, DIR_RIGHT, 5'd10, 8'h81, 5, 8'hFF);
      finish_resp("81_r10");
      send_cmd("3c_l0", 1'b0, DIR_LEFT, 5'd0, 8'h3C, 3, 8'h3C);
      finish_resp("3c_l0");

      c0 = sr_rst_cnt;
      send_cmd("3c_clr", 1'b1, DIR_LEFT, 5'd0, 8'h3C, 3, 8'h00);
      finish_resp("3c_clr");
      chk("clr_sr_rst_pulses", 32'(sr_rst_cnt - c0), 1);

      send_cmd("5a_l31", 1'b0, DIR_LEFT, 5'd31, 8'h5A, 8, 8'hFF);
      finish_resp("5a_l31");
      send_cmd("00_r7", 1'b0, DIR_RIGHT, 5'd7, 8'h00, 4, 8'hFE);
      finish_resp("00_r7");
      send_cmd("0f_l1", 1'b0, DIR_LEFT, 5'd1, 8'h0F, 4, 8'h1F);
      finish_resp("0f_l1");

      // response back-pressure with a stray command while busy
      c0 = sr_load_cnt;
      bus.rsp_ready = 1'b0;
      send_cmd("hold", 1'b0, DIR_LEFT, 5'd4, 8'h12, 4, 8'h2F);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_clr   = 1'b0;
            bus.cmd_amt   = 5'd9;
            bus.cmd_data  = 8'hEE;
         end
         chk("hold_valid", bus.rsp_valid, 1);
         chk("hold_data", bus.rsp_data, 8'h2F);
         chk("hold_cmd_ready", bus.cmd_ready, 0);
         @(posedge clk); #1;
         bus.cmd_valid = 1'b0;
      end
      finish_resp("hold");
      chk("hold_load_count", 32'(sr_load_cnt - c0), 1);

      // reset in the middle of a long shift
      exp_dir  = DIR_LEFT;
      exp_data = 8'h77;
      push_steps(31);
      exp_q.push_back(model_shift(8'h77, DIR_LEFT, 31));
      bus.cmd_valid = 1'b1;
      bus.cmd_clr   = 1'b0;
      bus.cmd_dir   = DIR_LEFT;
      bus.cmd_amt   = 5'd31;
      bus.cmd_data  = 8'h77;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      n = 0;
      while (sr_sh == 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_test_in_shift", sr_sh, 3'd7);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_sh_q.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("post_rst_cmd_ready", bus.cmd_ready, 1);
      chk("post_rst_rsp_data", bus.rsp_data, 8'h00);
      saw = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.rsp_valid) saw = 1'b1;
      end
      chk("post_rst_no_rsp", saw, 0);
      send_cmd("c3_r2", 1'b0, DIR_RIGHT, 5'd2, 8'hC3, 4, 8'hF0);
      finish_resp("c3_r2");

      repeat (2) @(posedge clk);
      #1;
      chk("sh_queue_empty", exp_sh_q.size(), 0);
      chk("rsp_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sh_reg_ctrl.md
SH_REG_CTRL -- requirements
Module: sh_reg_ctrl

Interface
REQ-001 Parameter: AMT_W, default 5, width of the requested total shift amount.
REQ-002 Parameter: MAX_STEP, default 7, largest per-cycle shift issued to the datapath (1..7).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: cmd_valid  in  1  command present.
REQ-006 Port: cmd_ready  out  1  controller can accept a command.
REQ-007 Port: cmd_clr  in  1  1 = clear command (datapath reset); the remaining cmd_* fields are ignored.
REQ-008 Port: cmd_dir  in  1  1 = shift right, 0 = shift left.
REQ-009 Port: cmd_amt  in  AMT_W  total shift amount.
REQ-010 Port: cmd_data  in  8  word to load before shifting.
REQ-011 Port: sr_rst / sr_load / sr_shift_r_l  out  1 each  shift-register control.
REQ-012 Port: sr_sh  out  3  per-cycle shift amount; sr_d_in  out  8  load data; sr_q  in  8  shift-register output.
REQ-013 Port: rsp_valid  out  1 / rsp_ready  in  1 / rsp_data  out  8  result handshake.
REQ-014 Port: busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, CLEAR, LOAD, SHIFT, SETTLE, RESP.
REQ-016 cmd_ready = 1 only in IDLE; accept = cmd_valid & cmd_ready; on accept, latch dir, amt and data.
REQ-017 Accept with cmd_clr=1 -> CLEAR: sr_rst=1 for exactly one cycle, then SETTLE.
REQ-018 Accept with cmd_clr=0 -> LOAD: sr_load=1 and sr_d_in=latched data for exactly one cycle.
REQ-019 LOAD -> SHIFT if amt != 0, otherwise -> SETTLE.
REQ-020 SHIFT: each cycle sr_sh = min(remaining, MAX_STEP) and sr_shift_r_l = dir; then remaining -= sr_sh. Exit to SETTLE after the cycle in which remaining reaches 0.
REQ-021 Step count = ceil(amt / MAX_STEP). Remaining counter is AMT_W bits wide and never underflows.
REQ-022 In every state other than SHIFT: sr_sh = 0 and sr_load = 0, so the datapath holds.
REQ-023 SETTLE: one cycle; rsp_data <= sr_q at its end; -> RESP.
REQ-024 RESP: rsp_valid=1 and rsp_data stable until rsp_ready=1; that cycle -> IDLE.
REQ-025 Latency for a load command, from the accept edge to rsp_valid high: 3 + steps cycles. For a clear command: 3 cycles.
REQ-026 rsp_ready held high already when RESP is entered: rsp_valid lasts exactly one cycle.
REQ-027 cmd_valid while busy: ignored, not latched, no side effects.
REQ-028 sr_sh and sr_d_in driven from registered state only; no combinational path from cmd_* to sr_*.

Reset
REQ-029 While rst=1, at the next edge: state = IDLE, remaining = 0, rsp_data = 0x00, and every latched field = 0.
REQ-030 sr_rst = rst OR (state == CLEAR), so the datapath is cleared together with the controller.
REQ-031 While rst=1: cmd_ready, rsp_valid, busy, sr_load, sr_sh and sr_d_in all read 0.
REQ-032 Reset mid-operation (any state): the operation is abandoned, no response is issued, and cmd_ready=1 in the first cycle after rst falls.

Structure
REQ-033 The shared package sh_reg_pkg holds the state enum typedef, the DIR_RIGHT/DIR_LEFT constants and the MAX_STEP default.
REQ-034 No sub-module; a single FSM plus the step counter. The bench instantiates the existing shift register and drives it from sr_*.

Verification
REQ-035 Load 0xA5, right, amt=3 -> one SHIFT cycle with sr_sh=3; rsp_data=0xF4 (ones-fill model); rsp_valid 4 cycles after accept.
REQ-036 Load 0x81, right, amt=10 -> sr_sh sequence 7 then 3; rsp_data=0xFF; rsp_valid 5 cycles after accept.
REQ-037 Load 0x3C, left, amt=0 -> no SHIFT cycle; rsp_data=0x3C after 3 cycles. Repeat with cmd_clr=1 -> sr_rst pulses once; rsp_data=0x00.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stay stable; a cmd_valid pulse during those cycles is ignored.
REQ-039 Assert rst during SHIFT of an amt=31 command -> no rsp_valid ever rises; cmd_ready=1 on the first cycle after reset; the next command completes normally.
REQ-040 Left, amt=31, MAX_STEP=7 -> sr_sh sequence 7,7,7,7,3; remaining counter never wraps.
